// File: rtl/regfl_arb_pkg.sv
// regfl_arb_pkg -- shared constants and FSM state encoding for regfl_arb.
//   NREQ_DEF / DW_DEF / AW_DEF : default requester count, data width, select width
//   NREG                       : number of registers in the attached register file
//   state_t                    : ST_ARB (arbitrating) / ST_CLR (clear sweep running)
package regfl_arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int DW_DEF   = 64;
    localparam int AW_DEF   = 3;
    localparam int NREG     = 8;

    typedef enum logic {
        ST_ARB = 1'b0,
        ST_CLR = 1'b1
    } state_t;

endpackage

// File: rtl/regfl_arb_rr_arb.sv
// rr_arb -- combinational round-robin picker.
// Requester k is req bit NREQ-1-k (requester 0 in the MSB), matching the
// MSB-first packing of addr/data in regfl_arb. The search starts at
// requester ptr and walks upward with wrap; the first active requester wins.
//   req  : in,  NREQ         active requests
//   ptr  : in,  PW           requester index to search from
//   pick : out, NREQ         one-hot pick (all zero when req is zero)
module rr_arb #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] pick
);

    int  idx;
    logic found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[NREQ-1-idx]) begin
                pick[NREQ-1-idx] = 1'b1;
                found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfl_arb.sv
// regfl_arb -- round-robin write arbiter in front of an 8 x DW register file,
// with an optional full-clear sweep.
// Optional feature macro: REGFL_ARB_CLR_EN (adds the ST_CLR state and sweep
// counter; without it the FSM stays in ST_ARB, clr_start is ignored and
// clr_busy is tied 0).
//
// Handshake: a requester raises req and holds req/addr/data stable until it
// sees its gnt bit. gnt, rf_we, rf_s and rf_d are registered together, so
// they appear in the cycle after the selecting edge. req still high in the
// cycle gnt is seen is treated as a fresh request.
//
// Requester k owns req/gnt bit NREQ-1-k, addr[AW*(NREQ-1-k) +: AW] and
// data[DW*(NREQ-1-k) +: DW] (requester 0 in the MSBs).
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   req        : in,  NREQ      write requests
//   addr, data : in,  NREQ*AW / NREQ*DW packed selects and data
//   gnt        : out, NREQ      one-hot one-cycle grant
//   clr_start  : in,  1         start a clear sweep (ST_ARB only)
//   clr_busy   : out, 1         sweep writes in progress
//   rf_we/rf_s/rf_d : out       register-file write port (we, s, d)
//   dbg_state  : out            current FSM state
//   dbg_ptr    : out, PW        round-robin pointer
module regfl_arb
    import regfl_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF,
    parameter int AW   = AW_DEF,
    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] data,
    output logic [NREQ-1:0]   gnt,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              rf_we,
    output logic [AW-1:0]     rf_s,
    output logic [DW-1:0]     rf_d,
    output state_t            dbg_state,
    output logic [PW-1:0]     dbg_ptr
);

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr, ptr_nxt;
    logic [NREQ-1:0] pick;
    logic [NREQ-1:0] gnt_nxt;
    logic            we_nxt;
    logic [AW-1:0]   s_nxt;
    logic [DW-1:0]   d_nxt;

    // Decoded view of the picked requester
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic [PW-1:0]   sel_ptr;

`ifdef REGFL_ARB_CLR_EN
    logic [AW-1:0]   cnt, cnt_nxt;
    logic            busy_q, busy_nxt;
`else
    logic            unused_clr;
    assign unused_clr = clr_start;
`endif

    rr_arb #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_arb (
        .req  (req),
        .ptr  (ptr),
        .pick (pick)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_ptr  = ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (pick[NREQ-1-k]) begin
                sel_addr = addr[AW*(NREQ-1-k) +: AW];
                sel_data = data[DW*(NREQ-1-k) +: DW];
                // Next search starts just after the winner, wrapping to 0
                sel_ptr  = (k == NREQ-1) ? '0 : PW'(k + 1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gnt_nxt   = '0;
        we_nxt    = 1'b0;
        s_nxt     = rf_s;
        d_nxt     = rf_d;
`ifdef REGFL_ARB_CLR_EN
        cnt_nxt   = cnt;
        busy_nxt  = 1'b0;
`endif
        case (state)
            ST_ARB: begin
`ifdef REGFL_ARB_CLR_EN
                if (clr_start) begin
                    // Clear wins over pending requests; no grant this edge
                    state_nxt = ST_CLR;
                    cnt_nxt   = '0;
                end else
`endif
                if (|req) begin
                    gnt_nxt = pick;
                    we_nxt  = 1'b1;
                    s_nxt   = sel_addr;
                    d_nxt   = sel_data;
                    ptr_nxt = sel_ptr;
                end
            end
`ifdef REGFL_ARB_CLR_EN
            ST_CLR: begin
                // One zero write per edge; clr_start is not looked at here
                we_nxt   = 1'b1;
                s_nxt    = cnt;
                d_nxt    = '0;
                busy_nxt = 1'b1;
                cnt_nxt  = cnt + 1'b1;
                if (cnt == '1) state_nxt = ST_ARB;
            end
`endif
            default: state_nxt = ST_ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_ARB;
            ptr   <= '0;
            gnt   <= '0;
            rf_we <= 1'b0;
            rf_s  <= '0;
            rf_d  <= '0;
`ifdef REGFL_ARB_CLR_EN
            cnt    <= '0;
            busy_q <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            gnt   <= gnt_nxt;
            rf_we <= we_nxt;
            rf_s  <= s_nxt;
            rf_d  <= d_nxt;
`ifdef REGFL_ARB_CLR_EN
            cnt    <= cnt_nxt;
            busy_q <= busy_nxt;
`endif
        end
    end

`ifdef REGFL_ARB_CLR_EN
    assign clr_busy = busy_q;
`else
    assign clr_busy = 1'b0;
`endif

    assign dbg_state = state;
    assign dbg_ptr   = ptr;

endmodule

// File: tb/tb_regfl_arb.sv
module tb_regfl_arb;
    import regfl_arb_pkg::*;

    logic         clk;
    logic         rst;
    logic [3:0]   req;
    logic [11:0]  addr;
    logic [255:0] data;
    logic [3:0]   gnt;
    logic         clr_start;
    logic         clr_busy;
    logic         rf_we;
    logic [2:0]   rf_s;
    logic [63:0]  rf_d;
    state_t       dbg_state;
    logic [1:0]   dbg_ptr;

    int checks;
    int errors;

    regfl_arb #(.NREQ(4), .DW(64), .AW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .addr      (addr),
        .data      (data),
        .gnt       (gnt),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .rf_we     (rf_we),
        .rf_s      (rf_s),
        .rf_d      (rf_d),
        .dbg_state (dbg_state),
        .dbg_ptr   (dbg_ptr)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // checker
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int k, input logic [2:0] a, input logic [63:0] d);
        addr[3*(3-k) +: 3]  = a;
        data[64*(3-k) +: 64] = d;
    endtask

    logic [3:0] exp_g;

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        req       = '0;
        addr      = '0;
        data      = '0;
        clr_start = 1'b0;
        step();
        step();

        // reset state
        check("rst_gnt",   64'(gnt), 64'h0);
        check("rst_we",    64'(rf_we), 64'h0);
        check("rst_s",     64'(rf_s), 64'h0);
        check("rst_d",     rf_d, 64'h0);
        check("rst_busy",  64'(clr_busy), 64'h0);
        check("rst_state", 64'(dbg_state), 64'(ST_ARB));
        check("rst_ptr",   64'(dbg_ptr), 64'h0);
        rst = 1'b0;

        // single request from requester 3 (req bit 0, addr/data LSB slot)
        set_slot(3, 3'd5, 64'hDEAD_BEEF_0000_0001);
        req = 4'b0001;
        step();
        req = 4'b0000;
        check("single_gnt", 64'(gnt), 64'h1);
        check("single_we",  64'(rf_we), 64'h1);
        check("single_s",   64'(rf_s), 64'h5);
        check("single_d",   rf_d, 64'hDEAD_BEEF_0000_0001);
        step();
        // idle: no write, select and data hold
        check("idle_gnt", 64'(gnt), 64'h0);
        check("idle_we",  64'(rf_we), 64'h0);
        check("idle_s",   64'(rf_s), 64'h5);
        check("idle_d",   rf_d, 64'hDEAD_BEEF_0000_0001);
        check("idle_ptr", 64'(dbg_ptr), 64'h0);

        // round robin: all four held for 8 cycles, starting at requester 0
        for (int k = 0; k < 4; k++) set_slot(k, 3'(k + 1), 64'h1000 + 64'(k));
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            step();
            exp_g = 4'b1000 >> (i % 4);
            check("rr_gnt", 64'(gnt), 64'(exp_g));
            check("rr_s",   64'(rf_s), 64'((i % 4) + 1));
            check("rr_d",   rf_d, 64'h1000 + 64'(i % 4));
        end
        req = 4'b0000;
        step();
        check("rr_ptr", 64'(dbg_ptr), 64'h0);

        // pointer advance and wrap: grant requester 2, then 0 beats 2 (ptr=3 wraps to 0)
        req = 4'b0010;
        step();
        check("ptr_g2", 64'(gnt), 64'b0010);
        req = 4'b1010;
        step();
        check("ptr_wrap_gnt", 64'(gnt), 64'b1000);
        check("ptr_wrap_s",   64'(rf_s), 64'h1);
        req = 4'b0000;
        step();
        check("ptr_after", 64'(dbg_ptr), 64'h1);

`ifdef REGFL_ARB_CLR_EN
        // clear vs request: sweep first, requester 0 after it
        set_slot(0, 3'd6, 64'h0BAD_F00D_0000_0006);
        req       = 4'b1000;
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        check("clr_entry_gnt",   64'(gnt), 64'h0);
        check("clr_entry_state", 64'(dbg_state), 64'(ST_CLR));
        for (int i = 0; i < 8; i++) begin
            step();
            check("clr_busy", 64'(clr_busy), 64'h1);
            check("clr_we",   64'(rf_we), 64'h1);
            check("clr_s",    64'(rf_s), 64'(i));
            check("clr_d",    rf_d, 64'h0);
            check("clr_gnt",  64'(gnt), 64'h0);
        end
        step();
        req = 4'b0000;
        check("post_clr_gnt",  64'(gnt), 64'b1000);
        check("post_clr_s",    64'(rf_s), 64'h6);
        check("post_clr_busy", 64'(clr_busy), 64'h0);
        step();

        // ignored restart: clr_start pulsed while rf_s=4
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            clr_start = 1'b0;
            check("rst2_s", 64'(rf_s), 64'(i));
            if (i == 4) clr_start = 1'b1;
        end
        clr_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst2_we_after",   64'(rf_we), 64'h0);
            check("rst2_busy_after", 64'(clr_busy), 64'h0);
        end

        // mid-sweep reset after rf_s=3
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("mid_s3", 64'(rf_s), 64'h3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_we",    64'(rf_we), 64'h0);
        check("mid_busy",  64'(clr_busy), 64'h0);
        check("mid_state", 64'(dbg_state), 64'(ST_ARB));
        check("mid_ptr",   64'(dbg_ptr), 64'h0);
        step();
        check("mid_no_write", 64'(rf_we), 64'h0);
`else
        // ARB-only build: clr_start has no effect
        set_slot(2, 3'd2, 64'h0000_0000_CAFE_0002);
        clr_start = 1'b1;
        req       = 4'b0100;
        step();
        clr_start = 1'b0;
        req       = 4'b0000;
        check("noclr_gnt",   64'(gnt), 64'b0100);
        check("noclr_s",     64'(rf_s), 64'h2);
        check("noclr_busy",  64'(clr_busy), 64'h0);
        check("noclr_state", 64'(dbg_state), 64'(ST_ARB));
        step();
        check("noclr_busy2", 64'(clr_busy), 64'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
